// File: rtl/pattern_counter.sv
// pattern_counter
// Counts every occurrence of PATTERN inside one DATA_W-bit word, overlapping
// matches included, and registers the saturated count one cycle later.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din_valid    din is accepted on a clk edge when high
//   din          word to search
//   count        registered match count of the last accepted word (saturating)
//   count_valid  one-cycle pulse per accepted word
//   match_vec    per-window match flags of the last accepted word
//                (present only when PATTERN_COUNTER_MATCH_VEC_EN is defined)
//
// Optional build macro: PATTERN_COUNTER_MATCH_VEC_EN
module pattern_counter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PAT_W = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b010,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic [CNT_W-1:0]  count,
  output logic              count_valid
`ifdef PATTERN_COUNTER_MATCH_VEC_EN
  ,
  output logic [DATA_W-PAT_W:0] match_vec
`endif
);

  // Number of windows and the width needed to hold their full sum.
  localparam int unsigned NWIN = DATA_W - PAT_W + 1;
  localparam int unsigned SUM_W = $clog2(NWIN + 1);
  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

  logic [NWIN-1:0]  win_match_c;
  logic [SUM_W-1:0] raw_total_c;
  logic [CNT_W-1:0] sat_total_c;

  // One comparator per window; windows never wrap past the word ends.
  for (genvar gi = 0; gi < NWIN; gi++) begin : g_win
    assign win_match_c[gi] = (din[gi +: PAT_W] == PATTERN);
  end

  // Population count of the window matches.
  always_comb begin
    raw_total_c = '0;
    for (int unsigned i = 0; i < NWIN; i++) begin
      raw_total_c = raw_total_c + SUM_W'(win_match_c[i]);
    end
  end

  // Clamp to the largest representable count instead of wrapping.
  always_comb begin
    sat_total_c = CNT_W'(raw_total_c);
    if (32'(raw_total_c) > CNT_MAX) begin
      sat_total_c = CNT_W'(CNT_MAX);
    end
  end

  // Result registers; count holds on idle cycles, the valid flag does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= din_valid;
      if (din_valid) begin
        count <= sat_total_c;
      end
    end
  end

`ifdef PATTERN_COUNTER_MATCH_VEC_EN
  // Per-window flags travel with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_vec <= '0;
    end else if (din_valid) begin
      match_vec <= win_match_c;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_counter.sv
// tb_pattern_counter
// Drives a default pattern_counter (32-bit word, pattern 010, 4-bit count) and
// a popcount-style instance (pattern 1, 4-bit count) from the same stimulus,
// and compares both against a window-scanning reference model.
module tb_pattern_counter;

  logic        clk;
  logic        clk_run;
  logic        rst_n;
  logic        din_valid;
  logic [31:0] din;
  logic [3:0]  count;
  logic        count_valid;
  logic [3:0]  sat_count;
  logic        sat_count_valid;
`ifdef PATTERN_COUNTER_MATCH_VEC_EN
  logic [29:0] match_vec;
  logic [31:0] sat_match_vec;
`endif

  int checks;
  int errors;

  // Reference state
  int          exp_count;
  logic        exp_valid;
  int          exp_sat;
  logic [29:0] exp_vec;
  logic [31:0] exp_sat_vec;

  pattern_counter u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_valid   (din_valid),
    .din         (din),
    .count       (count),
    .count_valid (count_valid)
`ifdef PATTERN_COUNTER_MATCH_VEC_EN
    ,
    .match_vec   (match_vec)
`endif
  );

  pattern_counter #(
    .DATA_W  (32),
    .PAT_W   (1),
    .PATTERN (1'b1),
    .CNT_W   (4)
  ) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_valid   (din_valid),
    .din         (din),
    .count       (sat_count),
    .count_valid (sat_count_valid)
`ifdef PATTERN_COUNTER_MATCH_VEC_EN
    ,
    .match_vec   (sat_match_vec)
`endif
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Number of windows of width pw equal to pat, clamped to 2^cw-1.
  function automatic int ref_count(input logic [31:0] w, input int pw,
                                   input logic [31:0] pat, input int cw);
    int n;
    logic [31:0] mask;
    n = 0;
    mask = (32'd1 << pw) - 32'd1;
    for (int i = 0; i <= 32 - pw; i++) begin
      if (((w >> i) & mask) == pat) n++;
    end
    if (n > (1 << cw) - 1) n = (1 << cw) - 1;
    return n;
  endfunction

  function automatic logic [31:0] ref_vec(input logic [31:0] w, input int pw,
                                          input logic [31:0] pat);
    logic [31:0] v;
    logic [31:0] mask;
    v = '0;
    mask = (32'd1 << pw) - 32'd1;
    for (int i = 0; i <= 32 - pw; i++) begin
      v[i] = (((w >> i) & mask) == pat);
    end
    return v;
  endfunction

  task automatic model_reset();
    exp_count = 0;
    exp_valid = 1'b0;
    exp_sat = 0;
    exp_vec = '0;
    exp_sat_vec = '0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_cnt"}, 64'(count), 64'(exp_count));
    check({tag, "_vld"}, 64'(count_valid), 64'(exp_valid));
    check({tag, "_sat"}, 64'(sat_count), 64'(exp_sat));
    check({tag, "_svld"}, 64'(sat_count_valid), 64'(exp_valid));
`ifdef PATTERN_COUNTER_MATCH_VEC_EN
    check({tag, "_vec"}, 64'(match_vec), 64'(exp_vec));
    check({tag, "_svec"}, 64'(sat_match_vec), 64'(exp_sat_vec));
`endif
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // compare 1 time unit later. Idle words are driven as X.
  task automatic step(input logic v, input logic [31:0] d, input string tag);
    @(negedge clk);
    din_valid = v;
    din = v ? d : 'x;
    @(posedge clk);
    if (rst_n) begin
      exp_valid = v;
      if (v) begin
        exp_count = ref_count(d, 3, 32'd2, 4);
        exp_sat = ref_count(d, 1, 32'd1, 4);
        exp_vec = 30'(ref_vec(d, 3, 32'd2));
        exp_sat_vec = ref_vec(d, 1, 32'd1);
      end
    end
    #1;
    compare_all(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_run = 1'b0;
    rst_n = 1'b1;
    din_valid = 1'b0;
    din = '0;
    model_reset();

    // Asynchronous reset with the clock stopped.
    #3 rst_n = 1'b0;
    #1;
    check("rst_cnt", 64'(count), 64'd0);
    check("rst_vld", 64'(count_valid), 64'd0);
    check("rst_sat", 64'(sat_count), 64'd0);
`ifdef PATTERN_COUNTER_MATCH_VEC_EN
    check("rst_vec", 64'(match_vec), 64'd0);
`endif
    #5 rst_n = 1'b1;
    clk_run = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, "idle");

    // Directed single words with literal expectations.
    step(1'b1, 32'hFFFF_FFFF, "w_ff");
    check("lit_ff", 64'(count), 64'd0);
    step(1'b0, 32'h0, "gap0");
    step(1'b1, 32'h0000_0004, "w_04");
    check("lit_04", 64'(count), 64'd1);
`ifdef PATTERN_COUNTER_MATCH_VEC_EN
    check("lit_vec04", 64'(match_vec), 64'h2);
`endif
    step(1'b0, 32'h0, "gap1");
    step(1'b1, 32'h0000_0055, "w_55");
    check("lit_55", 64'(count), 64'd3);
    step(1'b0, 32'h0, "gap2");
    step(1'b1, 32'h4924_9249, "w_49");
    check("lit_49", 64'(count), 64'd10);
    step(1'b0, 32'h0, "gap3");
    step(1'b1, 32'h5555_5555, "w_5555");
    check("lit_5555", 64'(count), 64'd15);
    step(1'b0, 32'h0, "gap4");

    // Back-to-back words, then idle.
    step(1'b1, 32'h0000_0004, "b2b0");
    check("b2b0_lit", 64'({count_valid, count}), 64'h11);
    step(1'b1, 32'h0000_0055, "b2b1");
    check("b2b1_lit", 64'({count_valid, count}), 64'h13);
    step(1'b1, 32'hFFFF_FFFF, "b2b2");
    check("b2b2_lit", 64'({count_valid, count}), 64'h10);
    step(1'b0, 32'h0, "b2b_idle");
    check("b2b_idle_lit", 64'({count_valid, count}), 64'h00);

    // Saturation on the single-bit-pattern instance.
    step(1'b1, 32'hFFFF_FFFF, "sat");
    check("sat_lit", 64'(sat_count), 64'd15);

    // Mid-stream reset: the word presented during reset is discarded.
    step(1'b1, 32'h0000_0004, "mr_pre");
    @(negedge clk);
    din_valid = 1'b1;
    din = 32'h4924_9249;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mr_async_cnt", 64'(count), 64'd0);
    check("mr_async_vld", 64'(count_valid), 64'd0);
    @(posedge clk);
    #1;
    compare_all("mr_held");
    @(negedge clk);
    rst_n = 1'b1;
    din_valid = 1'b0;
    step(1'b1, 32'h0000_0055, "mr_post");
    check("mr_post_lit", 64'(count), 64'd3);

    // Randomized stream against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      case ($urandom_range(0, 5))
        0: w = 32'h5555_5555 ^ (32'd1 << $urandom_range(0, 31));
        1: w = 32'h4924_9249 << $urandom_range(0, 2);
        2: w = $urandom & $urandom;
        default: w = $urandom;
      endcase
      step(($urandom_range(0, 3) != 0), w, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
